// File: rtl/lcplc_bit_unpacker.sv
// rtl/lcplc_bit_unpacker.sv - LCPLC decoder front end: packed word stream to variable-length fields
//
// Purpose:
//   Receives the coder's packed word stream (MSB-first bit packing) and serves
//   variable-length fields of 0..W bits to the decoding FSMs. A 2W-bit shift
//   buffer lets a field straddle a word boundary without stalling the requester.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   input_data/valid/ready/last  AXIS word input, first stream bit at MSB
//   req_length/align/valid/ready field request (length 0..W, or align-to-word)
//   output_data/valid/ready/last field result, right-aligned, zero-extended;
//                                output_last marks the final bit of the stream

module lcplc_bit_unpacker #(
  parameter int WORD_WIDTH_LOG = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [(2**WORD_WIDTH_LOG)-1:0]  input_data,
  input  logic                            input_valid,
  output logic                            input_ready,
  input  logic                            input_last,
  input  logic [WORD_WIDTH_LOG:0]         req_length,
  input  logic                            req_align,
  input  logic                            req_valid,
  output logic                            req_ready,
  output logic [(2**WORD_WIDTH_LOG)-1:0]  output_data,
  output logic                            output_valid,
  input  logic                            output_ready,
  output logic                            output_last
);

  localparam int W  = 2**WORD_WIDTH_LOG;
  localparam int BW = 2*W;
  localparam int CW = WORD_WIDTH_LOG+2;
  localparam int LW = WORD_WIDTH_LOG+1;

  // Shift buffer: valid bits left-justified, bits below count are always zero
  logic [BW-1:0] shift_q, shift_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_in_buf_q, last_in_buf_d;

  // Single-entry request slot
  logic          slot_valid_q, slot_valid_d;
  logic [LW-1:0] slot_len_q, slot_len_d;
  logic          slot_align_q, slot_align_d;

  // Registered field result and the number of bits it will consume
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [CW-1:0] out_consume_q, out_consume_d;

  logic          in_fire, req_fire, out_fire;
  logic [LW-1:0] req_len_clamped;
  logic [CW-1:0] len_ext;
  logic [CW-1:0] align_bits;
  logic          field_ready;
  logic [CW-1:0] consume_eval;
  logic [BW-1:0] field_wide;
  logic [W-1:0]  field_data;
  logic          field_last;
  logic          load;
  logic [CW-1:0] consume_now;
  logic [CW-1:0] count_after;
  logic [BW-1:0] shifted;

  always_comb begin
    input_ready  = (count_q <= CW'(W)) & ~last_in_buf_q;
    req_ready    = ~slot_valid_q;
    output_valid = out_valid_q;
    output_data  = out_data_q;
    output_last  = out_last_q;

    in_fire  = input_valid & input_ready;
    req_fire = req_valid & req_ready;
    out_fire = out_valid_q & output_ready;

    req_len_clamped = (req_length > LW'(W)) ? LW'(W) : req_length;

    // Evaluate the pending request against the current buffer contents.
    // Words appended later land below the valid bits, so the evaluated
    // top bits are unaffected until the consume.
    len_ext     = CW'(slot_len_q);
    align_bits  = CW'(count_q[WORD_WIDTH_LOG-1:0]);
    field_ready = slot_align_q | (count_q >= len_ext) | last_in_buf_q;

    if (slot_align_q) begin
      consume_eval = align_bits;
    end else if (count_q < len_ext) begin
      consume_eval = count_q;   // short final field: take what remains
    end else begin
      consume_eval = len_ext;
    end

    // Zero fill below count makes a short final field come out MSB-aligned
    // and zero-padded; a shift of BW (length 0) yields zero.
    field_wide = shift_q >> (CW'(BW) - len_ext);
    field_data = slot_align_q ? '0 : field_wide[W-1:0];
    field_last = last_in_buf_q & (count_q == consume_eval);

    load = ~out_valid_q & slot_valid_q & field_ready;
  end

  // Output and slot next-state
  always_comb begin
    out_valid_d   = out_valid_q ? ~output_ready : (slot_valid_q & field_ready);
    out_data_d    = load ? field_data   : out_data_q;
    out_last_d    = load ? field_last   : out_last_q;
    out_consume_d = load ? consume_eval : out_consume_q;

    slot_valid_d = slot_valid_q;
    slot_len_d   = slot_len_q;
    slot_align_d = slot_align_q;
    if (out_fire) begin
      slot_valid_d = 1'b0;
    end
    if (req_fire) begin
      slot_valid_d = 1'b1;
      slot_len_d   = req_len_clamped;
      slot_align_d = req_align;
    end
  end

  // Buffer next-state: shift out consumed bits first, then append the
  // accepted word directly below the remaining valid bits.
  always_comb begin
    consume_now = out_fire ? out_consume_q : '0;
    count_after = count_q - consume_now;
    shifted     = shift_q << consume_now;

    shift_d = shifted;
    count_d = count_after;
    if (in_fire) begin
      shift_d = shifted | ({input_data, {W{1'b0}}} >> count_after);
      count_d = count_after + CW'(W);
    end

    last_in_buf_d = last_in_buf_q;
    if (out_fire && (count_d == '0)) begin
      last_in_buf_d = 1'b0;
    end
    if (in_fire && input_last) begin
      last_in_buf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      count_q       <= '0;
      last_in_buf_q <= 1'b0;
      slot_valid_q  <= 1'b0;
      slot_len_q    <= '0;
      slot_align_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_consume_q <= '0;
    end else begin
      shift_q       <= shift_d;
      count_q       <= count_d;
      last_in_buf_q <= last_in_buf_d;
      slot_valid_q  <= slot_valid_d;
      slot_len_q    <= slot_len_d;
      slot_align_q  <= slot_align_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_consume_q <= out_consume_d;
    end
  end

endmodule
